// File: rtl/instr_encoder_loader.sv
// Encodes RV32I field bundles (LOAD/STORE/RTYPE/ITYPE/BRANCH) and writes them sequentially to instruction memory.
// Optional immediate range checking is enabled by defining INSTR_ENC_RANGE_CHECK_EN.
module instr_encoder_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [2:0]        in_class_i,
    input  logic [2:0]        in_funct3_i,
    input  logic              in_funct7b5_i,
    input  logic [4:0]        in_rd_i,
    input  logic [4:0]        in_rs1_i,
    input  logic [4:0]        in_rs2_i,
    input  logic [12:0]       in_imm_i,
    input  logic              in_last_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ready_i,
    output logic              done_o,
    output logic [ADDR_W:0]   count_o,
    output logic              err_o
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

    // Address whose completed write fills the memory window.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BASE_ADDR - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                err_q, err_d;
    logic                last_q, last_d;
    logic                class_ok, range_ok, accept, reject, write_done, addr_full;
    logic [31:0]         enc_word;

    always_comb begin
        enc_word = 32'h0;
        case (in_class_i)
            3'd0: enc_word = {in_imm_i[11:0], in_rs1_i, in_funct3_i, in_rd_i, 7'b0000011};
            3'd1: enc_word = {in_imm_i[11:5], in_rs2_i, in_rs1_i, in_funct3_i, in_imm_i[4:0], 7'b0100011};
            3'd2: enc_word = {1'b0, in_funct7b5_i, 5'b0, in_rs2_i, in_rs1_i, in_funct3_i, in_rd_i, 7'b0110011};
            3'd3: begin
                if (in_funct3_i == 3'b001 || in_funct3_i == 3'b101)
                    enc_word = {1'b0, in_funct7b5_i, 5'b0, in_imm_i[4:0], in_rs1_i, in_funct3_i, in_rd_i, 7'b0010011};
                else
                    enc_word = {in_imm_i[11:0], in_rs1_i, in_funct3_i, in_rd_i, 7'b0010011};
            end
            3'd4: enc_word = {in_imm_i[12], in_imm_i[10:5], in_rs2_i, in_rs1_i, in_funct3_i,
                              in_imm_i[4:1], in_imm_i[11], 7'b1100011};
            default: enc_word = 32'h0;
        endcase
    end

`ifdef INSTR_ENC_RANGE_CHECK_EN
    always_comb begin
        range_ok = 1'b1;
        case (in_class_i)
            3'd0, 3'd1, 3'd3: range_ok = (in_imm_i[12] == in_imm_i[11]);
            3'd4:             range_ok = ~in_imm_i[0];
            default:          range_ok = 1'b1;
        endcase
    end
`else
    assign range_ok = 1'b1;
`endif

    assign class_ok   = (in_class_i <= 3'd4);
    assign accept     = (state_q == S_IDLE) && in_valid_i && class_ok && range_ok;
    assign reject     = (state_q == S_IDLE) && in_valid_i && !(class_ok && range_ok);
    assign write_done = (state_q == S_WRITE) && mem_ready_i;
    assign addr_full  = (addr_q == LAST_ADDR);

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_WRITE;
            S_WRITE: if (mem_ready_i) state_d = (last_q || addr_full) ? S_DONE : S_IDLE;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready_o = (state_q == S_IDLE);
        mem_we_o   = (state_q == S_WRITE);
        done_o     = (state_q == S_DONE);
    end

    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        err_d   = err_q;
        last_d  = last_q;
        if (accept) begin
            wdata_d = enc_word;
            last_d  = in_last_i;
        end
        if (reject) err_d = 1'b1;
        if (write_done) begin
            count_d = count_q + (ADDR_W+1)'(1);
            // A full window stops at the last address rather than wrapping.
            if (addr_full) err_d  = 1'b1;
            else           addr_d = addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q  <= ADDR_W'(BASE_ADDR);
            wdata_q <= 32'h0;
            count_q <= '0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            err_q   <= err_d;
            last_q  <= last_d;
        end
    end

    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign count_o     = count_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed cases plus randomized bundles against an arithmetic encoding model.
module tb_instr_encoder_loader;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        in_valid_i = 1'b0;
    logic [2:0]  in_class_i = '0;
    logic [2:0]  in_funct3_i = '0;
    logic        in_funct7b5_i = 1'b0;
    logic [4:0]  in_rd_i = '0, in_rs1_i = '0, in_rs2_i = '0;
    logic [12:0] in_imm_i = '0;
    logic        in_last_i = 1'b0;
    logic        mem_ready_i = 1'b0;

    logic        in_ready_o, mem_we_o, done_o, err_o;
    logic [7:0]  mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [8:0]  count_o;

    logic        in_ready2, mem_we2, done2, err2;
    logic [1:0]  mem_addr2;
    logic [31:0] mem_wdata2;
    logic [2:0]  count2;

    int checks = 0;
    int failures = 0;

    int exp_addr, exp_count;
    bit exp_err, exp_done;

    always #5 clk_i = ~clk_i;

    instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_class_i(in_class_i), .in_funct3_i(in_funct3_i), .in_funct7b5_i(in_funct7b5_i),
        .in_rd_i(in_rd_i), .in_rs1_i(in_rs1_i), .in_rs2_i(in_rs2_i), .in_imm_i(in_imm_i),
        .in_last_i(in_last_i), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i), .done_o(done_o),
        .count_o(count_o), .err_o(err_o));

    // Small window to exercise the address-full path.
    instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
        .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready2),
        .in_class_i(in_class_i), .in_funct3_i(in_funct3_i), .in_funct7b5_i(in_funct7b5_i),
        .in_rd_i(in_rd_i), .in_rs1_i(in_rs1_i), .in_rs2_i(in_rs2_i), .in_imm_i(in_imm_i),
        .in_last_i(in_last_i), .mem_we_o(mem_we2), .mem_addr_o(mem_addr2),
        .mem_wdata_o(mem_wdata2), .mem_ready_i(mem_ready_i), .done_o(done2),
        .count_o(count2), .err_o(err2));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_enc(input int cls, input int f3, input int f7, input int rd,
                                            input int rs1, input int rs2, input int imm);
        int regs;
        regs = (rs1 << 15) | (f3 << 12);
        case (cls)
            0: return 32'((imm & 'hFFF) << 20) | 32'(regs) | 32'(rd << 7) | 32'h03;
            1: return 32'(((imm >> 5) & 'h7F) << 25) | 32'(rs2 << 20) | 32'(regs)
                      | 32'((imm & 'h1F) << 7) | 32'h23;
            2: return 32'(f7 << 30) | 32'(rs2 << 20) | 32'(regs) | 32'(rd << 7) | 32'h33;
            3: if (f3 == 1 || f3 == 5)
                   return 32'(f7 << 30) | 32'((imm & 'h1F) << 20) | 32'(regs) | 32'(rd << 7) | 32'h13;
               else
                   return 32'((imm & 'hFFF) << 20) | 32'(regs) | 32'(rd << 7) | 32'h13;
            4: return 32'(((imm >> 12) & 1) << 31) | 32'(((imm >> 5) & 'h3F) << 25) | 32'(rs2 << 20)
                      | 32'(regs) | 32'(((imm >> 1) & 'hF) << 8) | 32'(((imm >> 11) & 1) << 7) | 32'h63;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit ref_legal(input int cls, input int imm);
        if (cls > 4) return 1'b0;
`ifdef INSTR_ENC_RANGE_CHECK_EN
        if ((cls == 0 || cls == 1 || cls == 3) && (((imm >> 12) & 1) != ((imm >> 11) & 1))) return 1'b0;
        if (cls == 4 && (imm & 1) == 1) return 1'b0;
`endif
        return 1'b1;
    endfunction

    task automatic do_reset();
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        exp_addr = 0; exp_count = 0; exp_err = 0; exp_done = 0;
    endtask

    task automatic send(input int cls, input int f3, input int f7, input int rd, input int rs1,
                        input int rs2, input int imm, input bit last, input int stall,
                        input logic [31:0] word, input string tag);
        int n;
        bit ok;
        ok = ref_legal(cls, imm);
        n = 0;
        while (!in_ready_o && n < 20) begin
            @(posedge clk_i); #1;
            n++;
        end
        check({tag, "_ready_wait"}, in_ready_o, 1'b1);
        in_valid_i = 1'b1; in_class_i = 3'(cls); in_funct3_i = 3'(f3); in_funct7b5_i = 1'(f7);
        in_rd_i = 5'(rd); in_rs1_i = 5'(rs1); in_rs2_i = 5'(rs2); in_imm_i = 13'(imm); in_last_i = last;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0; in_last_i = 1'b0;
        if (ok) begin
            for (int k = 0; k <= stall; k++) begin
                check({tag, "_we"}, mem_we_o, 1'b1);
                check({tag, "_addr"}, mem_addr_o, 64'(exp_addr));
                check({tag, "_data"}, mem_wdata_o, word);
                check({tag, "_busy"}, in_ready_o, 1'b0);
                mem_ready_i = (k == stall);
                @(posedge clk_i); #1;
            end
            mem_ready_i = 1'b0;
            exp_count++;
            if (exp_addr == 255) begin
                exp_err = 1; exp_done = 1;
            end else begin
                exp_addr++;
                exp_done = last;
            end
            check({tag, "_we_drop"}, mem_we_o, 1'b0);
            check({tag, "_count"}, count_o, 64'(exp_count));
            check({tag, "_next_addr"}, mem_addr_o, 64'(exp_addr));
            check({tag, "_done"}, done_o, exp_done);
        end else begin
            exp_err = 1;
            check({tag, "_no_write"}, mem_we_o, 1'b0);
            check({tag, "_still_ready"}, in_ready_o, 1'b1);
            check({tag, "_count_held"}, count_o, 64'(exp_count));
        end
        check({tag, "_err"}, err_o, exp_err);
    endtask

    initial begin
        int cls, f3, imm;
        exp_addr = 0; exp_count = 0; exp_err = 0; exp_done = 0;
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_ready", in_ready_o, 1'b1);
        check("rst_we", mem_we_o, 1'b0);
        check("rst_addr", mem_addr_o, 0);
        check("rst_wdata", mem_wdata_o, 0);
        check("rst_done", done_o, 1'b0);
        check("rst_count", count_o, 0);
        check("rst_err", err_o, 1'b0);
        rst_i = 1'b0;

        send(3, 0, 0, 1, 0, 0, 5,  1'b0, 0, 32'h00500093, "addi");
        send(0, 2, 0, 2, 1, 0, 8,  1'b0, 0, 32'h0080A103, "lw");
        send(1, 2, 0, 0, 1, 2, 12, 1'b0, 1, 32'h0020A623, "sw");
        send(2, 0, 1, 3, 1, 2, 0,  1'b0, 0, 32'h402081B3, "sub");

        check("full_done", done2, 1'b1);
        check("full_err", err2, 1'b1);
        check("full_count", count2, 4);
        check("full_ready", in_ready2, 1'b0);
        check("full_addr", mem_addr2, 3);

        send(4, 0, 0, 0, 1, 2, 'h1FFC, 1'b0, 3, 32'hFE208EE3, "beq");
        check("full_5th_no_write", mem_we2, 1'b0);
        check("full_5th_count", count2, 4);

        // Reset while a write is stalled.
        in_valid_i = 1'b1; in_class_i = 3'd3; in_funct3_i = 3'd0; in_rd_i = 5'd4; in_imm_i = 13'd1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        check("midrst_pending_we", mem_we_o, 1'b1);
        do_reset();
        check("midrst_we", mem_we_o, 1'b0);
        check("midrst_addr", mem_addr_o, 0);
        check("midrst_count", count_o, 0);
        check("midrst_ready", in_ready_o, 1'b1);
        check("midrst_err", err_o, 1'b0);

        send(7, 0, 0, 1, 1, 1, 0, 1'b0, 0, 32'h0, "illegal7");
        send(3, 0, 0, 0, 0, 0, 'h0800, 1'b0, 0, 32'h80000013, "imm_range");

        do_reset();
        send(3, 0, 0, 5, 0, 0, 7, 1'b0, 0, ref_enc(3, 0, 0, 5, 0, 0, 7), "prog_w0");
        send(2, 7, 0, 6, 5, 5, 0, 1'b1, 0, ref_enc(2, 7, 0, 6, 5, 5, 0), "prog_last");
        check("last_done", done_o, 1'b1);
        check("last_ready", in_ready_o, 1'b0);
        in_valid_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        check("done_hold_we", mem_we_o, 1'b0);
        check("done_hold_count", count_o, 2);
        check("done_hold_done", done_o, 1'b1);

        do_reset();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) cls = int'($urandom_range(5, 7));
            else cls = int'($urandom_range(0, 4));
            f3  = int'($urandom_range(0, 7));
            imm = int'($urandom_range(0, 8191));
            begin
                int f7, rd, rs1, rs2;
                f7 = int'($urandom_range(0, 1));
                rd = int'($urandom_range(0, 31));
                rs1 = int'($urandom_range(0, 31));
                rs2 = int'($urandom_range(0, 31));
                send(cls, f3, f7, rd, rs1, rs2, imm, 1'b0, int'($urandom_range(0, 2)),
                     ref_enc(cls, f3, f7, rd, rs1, rs2, imm), $sformatf("rand%0d", i));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
